// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: ALU op codes, MIPS field constants and the issue-register payload type.
package alu_issue_stage_pkg;

    localparam logic [3:0] ALU_OP_ADD    = 4'h0;
    localparam logic [3:0] ALU_OP_SUB    = 4'h1;
    localparam logic [3:0] ALU_OP_AND    = 4'h2;
    localparam logic [3:0] ALU_OP_OR     = 4'h3;
    localparam logic [3:0] ALU_OP_SRL    = 4'h4;
    localparam logic [3:0] ALU_OP_SRA    = 4'h5;
    localparam logic [3:0] ALU_OP_SLL    = 4'h6;
    localparam logic [3:0] ALU_OP_SLT    = 4'h7;
    localparam logic [3:0] ALU_OP_SLTU   = 4'h8;
    localparam logic [3:0] ALU_OP_NOR    = 4'h9;
    localparam logic [3:0] ALU_OP_XOR    = 4'hA;
    localparam logic [3:0] ALU_OP_PASS_A = 4'hB;
    localparam logic [3:0] ALU_OP_PASS_B = 4'hC;
    localparam logic [3:0] ALU_OP_ROTR   = 4'hD;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ovf_chk;
        logic        illegal;
        logic [31:0] pc;
    } issue_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational MIPS decode into ALU op, operands and check flags.
module alu_issue_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [3:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        ovf_chk,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] shamt_a;
    logic        unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm           = instr[15:0];
    assign shamt_a       = {27'b0, instr[10:6]};
    assign unused_fields = ^{instr[25:22], instr[20:16]};

    // Unrecognised encodings fall through to the defaults plus illegal=1.
    always_comb begin
        op      = ALU_OP_ADD;
        a       = '0;
        b       = '0;
        ovf_chk = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: case (funct)
                FUNCT_ADD, FUNCT_ADDU: begin a = rs; b = rt; ovf_chk = funct == FUNCT_ADD; end
                FUNCT_SUB, FUNCT_SUBU: begin op = ALU_OP_SUB; a = rs; b = rt; ovf_chk = funct == FUNCT_SUB; end
                FUNCT_AND:  begin op = ALU_OP_AND;  a = rs; b = rt; end
                FUNCT_OR:   begin op = ALU_OP_OR;   a = rs; b = rt; end
                FUNCT_XOR:  begin op = ALU_OP_XOR;  a = rs; b = rt; end
                FUNCT_NOR:  begin op = ALU_OP_NOR;  a = rs; b = rt; end
                FUNCT_SLT:  begin op = ALU_OP_SLT;  a = rs; b = rt; end
                FUNCT_SLTU: begin op = ALU_OP_SLTU; a = rs; b = rt; end
                FUNCT_SLL:  begin op = ALU_OP_SLL; a = shamt_a; b = rt; end
                FUNCT_SRL:  begin op = instr[21] ? ALU_OP_ROTR : ALU_OP_SRL; a = shamt_a; b = rt; end
                FUNCT_SRA:  begin op = ALU_OP_SRA; a = shamt_a; b = rt; end
                FUNCT_SLLV: begin op = ALU_OP_SLL; a = rs; b = rt; end
                FUNCT_SRLV: begin op = instr[6] ? ALU_OP_ROTR : ALU_OP_SRL; a = rs; b = rt; end
                FUNCT_SRAV: begin op = ALU_OP_SRA; a = rs; b = rt; end
                default:    illegal = 1'b1;
            endcase
            OPC_ADDI:          begin a = rs; b = sext16(imm); ovf_chk = 1'b1; end
            OPC_ADDIU:         begin a = rs; b = sext16(imm); end
            OPC_SLTI:          begin op = ALU_OP_SLT;  a = rs; b = sext16(imm); end
            OPC_SLTIU:         begin op = ALU_OP_SLTU; a = rs; b = sext16(imm); end
            OPC_ANDI:          begin op = ALU_OP_AND;  a = rs; b = zext16(imm); end
            OPC_ORI:           begin op = ALU_OP_OR;   a = rs; b = zext16(imm); end
            OPC_XORI:          begin op = ALU_OP_XOR;  a = rs; b = zext16(imm); end
            OPC_LUI:           begin op = ALU_OP_PASS_B; b = {imm, 16'h0000}; end
            OPC_LW, OPC_SW:    begin a = rs; b = sext16(imm); end
            OPC_BEQ, OPC_BNE:  begin op = ALU_OP_SUB; a = rs; b = rt; end
            OPC_JAL:           begin op = ALU_OP_PASS_A; a = pc + 32'd8; end
            default:           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue register with stall, flush and bubble insertion.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_alu_a,
    output logic [31:0] ex_alu_b,
    output logic [3:0]  ex_alu_op,
    output logic        ex_ovf_chk,
    output logic        ex_illegal,
    output logic [31:0] ex_pc
);

    localparam issue_t BUBBLE = '{valid: 1'b0, op: ALU_OP_ADD, a: '0, b: '0,
                                  ovf_chk: 1'b0, illegal: 1'b0, pc: RESET_PC};

    logic [3:0]  dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_ovf_chk;
    logic        dec_illegal;
    issue_t      nxt;
    issue_t      q;

    alu_issue_decode u_decode (
        .instr   (id_instr),
        .pc      (id_pc),
        .rs      (id_rs_data),
        .rt      (id_rt_data),
        .op      (dec_op),
        .a       (dec_a),
        .b       (dec_b),
        .ovf_chk (dec_ovf_chk),
        .illegal (dec_illegal)
    );

    always_comb begin
        nxt = id_valid ? '{valid: 1'b1, op: dec_op, a: dec_a, b: dec_b,
                           ovf_chk: dec_ovf_chk, illegal: dec_illegal, pc: id_pc} : BUBBLE;
    end

    // Flush is a bubble and takes priority over stall.
    always_ff @(posedge clk) begin
        if (reset || flush)
            q <= BUBBLE;
        else if (!stall)
            q <= nxt;
    end

    assign ex_valid   = q.valid;
    assign ex_alu_a   = q.a;
    assign ex_alu_b   = q.b;
    assign ex_alu_op  = q.op;
    assign ex_ovf_chk = q.ovf_chk;
    assign ex_illegal = q.illegal;
    assign ex_pc      = q.pc;

endmodule
